// File: rtl/wb_timeout_1x1.sv
// Wishbone watchdog/request stage: i_* one cycle after t_*, response one cycle after i_ack/i_err.
// Initiator is held (no t_ack) until termination, abort or TIMEOUT expiry with error.
module wb_timeout_1x1 #(
  parameter int WB_ADDR_WIDTH = 32,
  parameter int WB_DATA_WIDTH = 32,
  parameter int TIMEOUT       = 256
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic [WB_ADDR_WIDTH-1:0]   t_adr,
  input  logic [WB_DATA_WIDTH-1:0]   t_dat_w,
  output logic [WB_DATA_WIDTH-1:0]   t_dat_r,
  input  logic                       t_cyc,
  input  logic                       t_stb,
  input  logic                       t_we,
  input  logic [WB_DATA_WIDTH/8-1:0] t_sel,
  output logic                       t_ack,
  output logic                       t_err,
  output logic [WB_ADDR_WIDTH-1:0]   i_adr,
  output logic [WB_DATA_WIDTH-1:0]   i_dat_w,
  output logic [WB_DATA_WIDTH/8-1:0] i_sel,
  output logic                       i_we,
  output logic                       i_cyc,
  output logic                       i_stb,
  input  logic [WB_DATA_WIDTH-1:0]   i_dat_r,
  input  logic                       i_ack,
  input  logic                       i_err,
  output logic                       timeout,
  output logic [WB_ADDR_WIDTH-1:0]   timeout_adr
);

  localparam int SEL_W = WB_DATA_WIDTH / 8;
  localparam int CNT_W = $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t                   state, state_nxt;
  logic [CNT_W-1:0]         cnt, cnt_nxt;
  logic [WB_ADDR_WIDTH-1:0] i_adr_nxt;
  logic [WB_DATA_WIDTH-1:0] i_dat_w_nxt;
  logic [SEL_W-1:0]         i_sel_nxt;
  logic                     i_we_nxt;
  logic                     i_cyc_nxt;
  logic                     i_stb_nxt;
  logic                     t_ack_nxt;
  logic                     t_err_nxt;
  logic [WB_DATA_WIDTH-1:0] t_dat_r_nxt;
  logic                     timeout_nxt;
  logic [WB_ADDR_WIDTH-1:0] timeout_adr_nxt;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      cnt         <= '0;
      i_adr       <= '0;
      i_dat_w     <= '0;
      i_sel       <= '0;
      i_we        <= 1'b0;
      i_cyc       <= 1'b0;
      i_stb       <= 1'b0;
      t_ack       <= 1'b0;
      t_err       <= 1'b0;
      t_dat_r     <= '0;
      timeout     <= 1'b0;
      timeout_adr <= '0;
    end else begin
      state       <= state_nxt;
      cnt         <= cnt_nxt;
      i_adr       <= i_adr_nxt;
      i_dat_w     <= i_dat_w_nxt;
      i_sel       <= i_sel_nxt;
      i_we        <= i_we_nxt;
      i_cyc       <= i_cyc_nxt;
      i_stb       <= i_stb_nxt;
      t_ack       <= t_ack_nxt;
      t_err       <= t_err_nxt;
      t_dat_r     <= t_dat_r_nxt;
      timeout     <= timeout_nxt;
      timeout_adr <= timeout_adr_nxt;
    end
  end

  always_comb begin
    state_nxt       = state;
    cnt_nxt         = cnt;
    i_adr_nxt       = i_adr;
    i_dat_w_nxt     = i_dat_w;
    i_sel_nxt       = i_sel;
    i_we_nxt        = i_we;
    i_cyc_nxt       = i_cyc;
    i_stb_nxt       = i_stb;
    t_ack_nxt       = 1'b0;
    t_err_nxt       = 1'b0;
    t_dat_r_nxt     = t_dat_r;
    timeout_nxt     = 1'b0;
    timeout_adr_nxt = timeout_adr;

    case (state)
      IDLE: begin
        if (t_cyc && t_stb) begin
          i_adr_nxt   = t_adr;
          i_dat_w_nxt = t_dat_w;
          i_sel_nxt   = t_sel;
          i_we_nxt    = t_we;
          i_cyc_nxt   = 1'b1;
          i_stb_nxt   = 1'b1;
          cnt_nxt     = '0;
          state_nxt   = BUSY;
        end
      end

      BUSY: begin
        // Saturate rather than wrap; expiry always leaves BUSY anyway.
        if (cnt != CNT_MAX) begin
          cnt_nxt = cnt + CNT_W'(1);
        end
        if (!t_cyc) begin
          i_cyc_nxt = 1'b0;
          i_stb_nxt = 1'b0;
          state_nxt = IDLE;
        end else if (i_err) begin
          i_cyc_nxt   = 1'b0;
          i_stb_nxt   = 1'b0;
          t_err_nxt   = 1'b1;
          t_dat_r_nxt = '0;
          state_nxt   = RESP;
        end else if (i_ack) begin
          i_cyc_nxt   = 1'b0;
          i_stb_nxt   = 1'b0;
          t_ack_nxt   = 1'b1;
          t_dat_r_nxt = i_dat_r;
          state_nxt   = RESP;
        end else if (cnt == CNT_MAX) begin
          i_cyc_nxt       = 1'b0;
          i_stb_nxt       = 1'b0;
          t_err_nxt       = 1'b1;
          t_dat_r_nxt     = '0;
          timeout_nxt     = 1'b1;
          timeout_adr_nxt = i_adr;
          state_nxt       = RESP;
        end
      end

      // The initiator still shows the finished request here, so t_stb is not sampled.
      RESP: begin
        state_nxt = IDLE;
      end

      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

endmodule

// File: doc/wb_timeout_1x1.md
# wb_timeout_1x1

Single-initiator Wishbone watchdog and request register stage, placed between a bus initiator (CPU or DMA) and the target port of `wb_interconnect_1xN`. It registers each request and forwards it to the interconnect. It returns the interconnect's ack, err and read data one cycle later. If no ack or err arrives within TIMEOUT cycles, it terminates the cycle with an error and captures the offending address. Without it, a decode hole or a hung target stalls the initiator indefinitely.

## Interface
- WB_ADDR_WIDTH, 32, address width
- WB_DATA_WIDTH, 32, data width (multiple of 8)
- TIMEOUT, 256, maximum number of cycles `i_stb` stays high awaiting ack/err (≥2)
- clock  in  1  sole clock; everything is sampled on its rising edge
- reset  in  1  asynchronous, active-low reset
- t_adr  in  WB_ADDR_WIDTH  initiator address
- t_dat_w  in  WB_DATA_WIDTH  initiator write data
- t_dat_r  out  WB_DATA_WIDTH  read data to initiator
- t_cyc, t_stb, t_we  in  1  initiator cycle / strobe / write enable
- t_sel  in  WB_DATA_WIDTH/8  byte selects
- t_ack, t_err  out  1  one-cycle termination pulses to initiator
- i_adr, i_dat_w, i_sel, i_we  out  as t_*  registered request to interconnect
- i_cyc, i_stb  out  1  registered cycle/strobe to interconnect
- i_dat_r  in  WB_DATA_WIDTH  interconnect read data
- i_ack, i_err  in  1  interconnect terminations
- timeout  out  1  one-cycle pulse when a timeout fires
- timeout_adr  out  WB_ADDR_WIDTH  address of the most recent timed-out request (holds its value)

## Operation
- All outputs are registered. While `reset` is low, every output is 0 and the FSM is in IDLE.
- FSM states: IDLE, BUSY, RESP.
- **IDLE:** on `t_cyc & t_stb`:
  - latch `t_adr`, `t_dat_w`, `t_sel` and `t_we` into the `i_*` registers;
  - set `i_cyc` and `i_stb` to 1;
  - clear the counter to 0;
  - go to BUSY.
- **BUSY:** the counter increments every cycle. Priority order:
  1. `t_cyc == 0` (initiator abort): clear `i_cyc`/`i_stb`, go to IDLE, give no response.
  2. `i_err`: clear `i_cyc`/`i_stb`, set `t_err` to 1, set `t_dat_r` to 0, go to RESP.
  3. `i_ack`: clear `i_cyc`/`i_stb`, set `t_ack` to 1, set `t_dat_r` to `i_dat_r`, go to RESP.
  4. Counter == TIMEOUT-1: clear `i_cyc`/`i_stb`, set `t_err` to 1, set `t_dat_r` to 0, set `timeout` to 1, set `timeout_adr` to `i_adr`, go to RESP.
- **RESP:** clear `t_ack`, `t_err` and `timeout`, go to IDLE. `t_stb` is ignored in this cycle; it is still the old request.
- Ack and err in the same cycle: err wins.
- Ack in the expiry cycle: ack wins and no timeout is raised.
- `i_ack`/`i_err` received while in IDLE or RESP (late response after a timeout or abort) are ignored.
- `i_adr`, `i_dat_w`, `i_sel` and `i_we` keep their last value after the cycle ends. `t_dat_r` keeps its value until the next termination.
- Counter width is `$clog2(TIMEOUT)`. It never wraps, because expiry exits BUSY.

## Timing
- Request sampled at edge 0. `i_stb` is high from cycle 1.
- Interconnect ack in cycle k (k≥1) → `t_ack` in cycle k+1, exactly one cycle wide.
- Minimum initiator-visible latency is 2 cycles (zero-wait target).
- Back-to-back: a new request can be accepted in the cycle after RESP, so the request rate is one per 3 cycles with zero-wait targets.
- Timeout: with no response, `i_stb` is high for exactly TIMEOUT cycles (1..TIMEOUT). `t_err` and `timeout` are both high in cycle TIMEOUT+1.
- Reset asserted mid-transaction: all outputs go to 0 immediately (asynchronous). After release the FSM is in IDLE and no response is issued for the interrupted request.

## Test plan
- **Read, zero-wait:** target returns `i_ack`=1 with `i_dat_r`=0xDEADBEEF in the first `i_stb` cycle → `t_ack`=1 and `t_dat_r`=0xDEADBEEF in cycle 2; `i_cyc`=0 in cycle 2.
- **Write, 3 wait states:** `t_adr`=0x28000010, `t_dat_w`=0x12345678, `t_sel`=0xF → `i_*` match in cycles 1–4, ack in cycle 4, `t_ack` in cycle 5, `timeout` stays 0.
- **Timeout, TIMEOUT=4:** request to 0x30000000 with no ack → `i_stb` high in cycles 1–4; in cycle 5 `t_err`=1, `timeout`=1, `timeout_adr`=0x30000000, `t_dat_r`=0. A late `i_ack` in cycle 6 is ignored.
- **Simultaneous events:** `i_ack` and `i_err` in the same cycle → only `t_err`. With TIMEOUT=4, `i_ack` in cycle 4 → `t_ack`, and `timeout` stays 0.
- **Abort:** `t_cyc` dropped in cycle 2 → `i_cyc`=0 in cycle 3; no `t_ack`/`t_err`; next request accepted normally.
- **Async reset:** `reset` asserted low in cycle 2 of a pending request → `i_cyc`, `i_stb` and `t_ack` are 0 before the next edge. After release, a fresh read completes with correct data.
